// File: rtl/wordcell_access_ctrl.sv
// Host-side access controller for an array of Wordcell rows: turns one valid/ready
// request into the SETUP / ACCESS / RECOVER select sequence and captures read data.
module wordcell_access_ctrl #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 2,
    parameter int ACCESS_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic                     rsp_write,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     busy,
    output logic                     rw,
    output logic [(2**ADDR_W)-1:0]   sel_x,
    output logic [DATA_W-1:0]        in_bus,
    input  logic [DATA_W-1:0]        out_bus
);

    localparam int ROWS = 2**ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYC - 1);
    localparam logic [ROWS-1:0] ONE_HOT0 = {{(ROWS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;

    assign req_ready = (state == IDLE) && !rst;

    // rw and in_bus are loaded on acceptance so they settle a full cycle before sel_x rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            rw        <= 1'b0;
            sel_x     <= '0;
            in_bus    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q   <= req_write;
                        addr_q <= req_addr;
                        rw     <= req_write;
                        in_bus <= req_write ? req_wdata : '0;
                        busy   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    sel_x <= ONE_HOT0 << addr_q;
                    cnt   <= CNT_INIT;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        sel_x     <= '0;
                        rsp_valid <= 1'b1;
                        rsp_write <= wr_q;
                        if (!wr_q) begin
                            rsp_rdata <= out_bus;
                        end
                        state <= RECOVER;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RECOVER: begin
                    rw     <= 1'b0;
                    in_bus <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wordcell_access_ctrl.sv
// Directed bench for wordcell_access_ctrl: two instances (ACCESS_CYC=1 and 3), each
// driving a small Wordcell row model, with immediate-assertion checks.
module tb_wordcell_access_ctrl;

    logic       clk = 1'b0;
    logic       rst;

    logic       req_valid1, req_ready1, req_write1;
    logic [1:0] req_addr1;
    logic [7:0] req_wdata1;
    logic       rsp_valid1, rsp_write1, busy1, rw1;
    logic [7:0] rsp_rdata1, in1, out1;
    logic [3:0] sel1;

    logic       req_valid3, req_ready3, req_write3;
    logic [1:0] req_addr3;
    logic [7:0] req_wdata3;
    logic       rsp_valid3, rsp_write3, busy3, rw3;
    logic [7:0] rsp_rdata3, in3, out3;
    logic [3:0] sel3;

    logic [7:0] mem1 [4];
    logic [7:0] mem3 [4];

    int checks = 0;
    int passes = 0;
    logic mon_en = 1'b0;
    logic prev_rw1, prev_rw3;
    logic [7:0] prev_in1, prev_in3;

    always #5 clk = ~clk;

    wordcell_access_ctrl #(.DATA_W(8), .ADDR_W(2), .ACCESS_CYC(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_write(rsp_write1), .rsp_rdata(rsp_rdata1),
        .busy(busy1), .rw(rw1), .sel_x(sel1), .in_bus(in1), .out_bus(out1)
    );

    wordcell_access_ctrl #(.DATA_W(8), .ADDR_W(2), .ACCESS_CYC(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
        .req_addr(req_addr3), .req_wdata(req_wdata3),
        .rsp_valid(rsp_valid3), .rsp_write(rsp_write3), .rsp_rdata(rsp_rdata3),
        .busy(busy3), .rw(rw3), .sel_x(sel3), .in_bus(in3), .out_bus(out3)
    );

    // Wordcell row model: selected row is written on a clock edge while rw is high.
    initial begin
        for (int i = 0; i < 4; i++) begin
            mem1[i] = 8'h00;
            mem3[i] = 8'h00;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rw1 && sel1[i]) mem1[i] <= in1;
            if (rw3 && sel3[i]) mem3[i] <= in3;
        end
    end

    always_comb begin
        out1 = 8'h00;
        out3 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (sel1[i]) out1 = out1 | mem1[i];
            if (sel3[i]) out3 = out3 | mem3[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Select must stay zero/one-hot, and rw/in_bus must not move while a row is selected.
    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("onehot_sel1", 32'($onehot0(sel1)), 32'd1);
            checkOutput("onehot_sel3", 32'($onehot0(sel3)), 32'd1);
            if (sel1 != 4'd0) begin
                checkOutput("rw1_stable", 32'(rw1), 32'(prev_rw1));
                checkOutput("in1_stable", 32'(in1), 32'(prev_in1));
            end
            if (sel3 != 4'd0) begin
                checkOutput("rw3_stable", 32'(rw3), 32'(prev_rw3));
                checkOutput("in3_stable", 32'(in3), 32'(prev_in3));
            end
        end
        prev_rw1 = rw1;
        prev_in1 = in1;
        prev_rw3 = rw3;
        prev_in3 = in3;
    end

    // One complete request on the ACCESS_CYC=1 instance, checked cycle by cycle.
    task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [7:0] d,
                                 input logic [7:0] exp_rdata);
        logic [7:0] exp_in;
        exp_in = w ? d : 8'h00;
        @(negedge clk);
        req_valid1 = 1'b1;
        req_write1 = w;
        req_addr1  = a;
        req_wdata1 = d;
        checkOutput("ready_before_accept", 32'(req_ready1), 32'd1);
        @(negedge clk);
        req_valid1 = 1'b0;
        checkOutput("setup_sel", 32'(sel1), 32'd0);
        checkOutput("setup_rw", 32'(rw1), 32'(w));
        checkOutput("setup_in_bus", 32'(in1), 32'(exp_in));
        checkOutput("setup_busy", 32'(busy1), 32'd1);
        checkOutput("setup_ready", 32'(req_ready1), 32'd0);
        checkOutput("setup_rsp_valid", 32'(rsp_valid1), 32'd0);
        @(negedge clk);
        checkOutput("access_sel", 32'(sel1), 32'(4'b0001 << a));
        checkOutput("access_rw", 32'(rw1), 32'(w));
        checkOutput("access_rsp_valid", 32'(rsp_valid1), 32'd0);
        @(negedge clk);
        checkOutput("recover_sel", 32'(sel1), 32'd0);
        checkOutput("recover_rw", 32'(rw1), 32'(w));
        checkOutput("recover_rsp_valid", 32'(rsp_valid1), 32'd1);
        checkOutput("recover_rsp_write", 32'(rsp_write1), 32'(w));
        checkOutput("recover_rdata", 32'(rsp_rdata1), 32'(exp_rdata));
        @(negedge clk);
        checkOutput("idle_rsp_valid", 32'(rsp_valid1), 32'd0);
        checkOutput("idle_ready", 32'(req_ready1), 32'd1);
        checkOutput("idle_rw", 32'(rw1), 32'd0);
        checkOutput("idle_in_bus", 32'(in1), 32'd0);
        checkOutput("idle_busy", 32'(busy1), 32'd0);
        checkOutput("idle_rdata_hold", 32'(rsp_rdata1), 32'(exp_rdata));
    endtask

    initial begin
        int acc_cyc[$];
        int pulses;
        int sel_cnt;
        int rv_k;
        logic acc;
        logic [7:0] rd3;

        rst = 1'b1;
        req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = 2'd0; req_wdata1 = 8'h00;
        req_valid3 = 1'b0; req_write3 = 1'b0; req_addr3 = 2'd0; req_wdata3 = 8'h00;

        // Reset then idle
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_ready", 32'(req_ready1), 32'd0);
            checkOutput("rst_sel", 32'(sel1), 32'd0);
            checkOutput("rst_rw", 32'(rw1), 32'd0);
            checkOutput("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
            checkOutput("rst_sel3", 32'(sel3), 32'd0);
        end
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", 32'(req_ready1), 32'd1);
        checkOutput("post_rst_busy", 32'(busy1), 32'd0);
        checkOutput("post_rst_rdata", 32'(rsp_rdata1), 32'd0);
        mon_en = 1'b1;

        // Write then read, row isolation
        applyStimulus(1'b1, 2'd2, 8'h55, 8'h00);
        applyStimulus(1'b0, 2'd2, 8'h00, 8'h55);
        applyStimulus(1'b1, 2'd1, 8'hCC, 8'h55);
        applyStimulus(1'b1, 2'd3, 8'h33, 8'h55);
        applyStimulus(1'b0, 2'd1, 8'h00, 8'hCC);
        applyStimulus(1'b0, 2'd3, 8'h00, 8'h33);

        // Back-to-back writes with req_valid held high
        pulses = 0;
        @(negedge clk);
        req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 2'd0; req_wdata1 = 8'hA0;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid1) pulses++;
            acc = req_ready1 && req_valid1;
            if (acc) acc_cyc.push_back(c);
            @(negedge clk);
            if (acc) begin
                if (acc_cyc.size() < 4) begin
                    req_addr1  = 2'(acc_cyc.size());
                    req_wdata1 = 8'hA0 + 8'(acc_cyc.size());
                end else begin
                    req_valid1 = 1'b0;
                end
            end
        end
        checkOutput("b2b_accept_count", 32'(acc_cyc.size()), 32'd4);
        checkOutput("b2b_pulse_count", 32'(pulses), 32'd4);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checkOutput("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
        end
        applyStimulus(1'b0, 2'd3, 8'h00, 8'hA3);
        applyStimulus(1'b0, 2'd0, 8'h00, 8'hA0);
        applyStimulus(1'b1, 2'd0, 8'h0F, 8'hA0);

        // Mid-operation reset during ACCESS of a read
        @(negedge clk);
        req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 2'd1;
        @(negedge clk);
        req_valid1 = 1'b0;
        @(negedge clk);
        checkOutput("midrst_in_access", 32'(sel1), 32'b0010);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_sel", 32'(sel1), 32'd0);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid1), 32'd0);
        checkOutput("midrst_rdata", 32'(rsp_rdata1), 32'd0);
        checkOutput("midrst_rw", 32'(rw1), 32'd0);
        checkOutput("midrst_ready", 32'(req_ready1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_no_rsp", 32'(rsp_valid1), 32'd0);
        applyStimulus(1'b0, 2'd0, 8'h00, 8'h0F);

        // ACCESS_CYC=3 instance: write A5 to row 0, then read it back
        @(negedge clk);
        req_valid3 = 1'b1; req_write3 = 1'b1; req_addr3 = 2'd0; req_wdata3 = 8'hA5;
        @(negedge clk);
        req_valid3 = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("ac3_idle_after_write", 32'(req_ready3), 32'd1);
        req_valid3 = 1'b1; req_write3 = 1'b0; req_addr3 = 2'd0;
        sel_cnt = 0;
        rv_k = 0;
        rd3 = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) req_valid3 = 1'b0;
            if (sel3 == 4'b0001) sel_cnt++;
            if (rsp_valid3 && rv_k == 0) begin
                rv_k = k;
                rd3 = rsp_rdata3;
                checkOutput("ac3_rsp_write", 32'(rsp_write3), 32'd0);
            end
        end
        checkOutput("ac3_sel_cycles", 32'(sel_cnt), 32'd3);
        checkOutput("ac3_rsp_latency", 32'(rv_k), 32'd5);
        checkOutput("ac3_rdata", 32'(rd3), 32'hA5);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wordcell_access_ctrl.md
Name: wordcell_access_ctrl

Overview:
- Host-side access controller that drives an array of 8-bit Wordcell rows.
- Converts a single-request valid/ready host interface into the array's native sequence: one-hot row select, rw, and in_bus. For reads it samples out_bus.
- Sequencing guarantees that rw and in_bus are stable for one full cycle before any sel_x is asserted. rw is held constant for as long as a select is high.
- Sits between the bus/CPU model and the Wordcell array. It is the initiator end of the Wordcell rw/sel_x/in_bus/out_bus interface.

Parameters:
- DATA_W, 8, word width; matches the Wordcell bus width.
- ADDR_W, 2, row address width; ROWS = 2**ADDR_W = 4.
- ACCESS_CYC, 1, number of cycles sel_x is held asserted (1..15).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  host request present.
- req_ready  out  1  controller idle and able to accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  row address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse that completes the request.
- rsp_write  out  1  echoes the type of the completed request.
- rsp_rdata  out  DATA_W  captured read data; holds its value until the next read completes.
- busy  out  1  high in every state except IDLE.
- rw  out  1  array rw line: 1 = write, 0 = read.
- sel_x  out  ROWS  one-hot row select; all zero when no access is in progress.
- in_bus  out  DATA_W  array write bus.
- out_bus  in  DATA_W  array read bus; comes from the selected row.

Behaviour:
- Reset values: state=IDLE, rw=0, sel_x=0, in_bus=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, busy=0.
- req_ready = (state==IDLE) && !rst, so req_ready is 0 in any cycle where rst is high.
- FSM states: IDLE -> SETUP -> ACCESS -> RECOVER -> IDLE.
- IDLE:
  - On clk edge with req_valid && req_ready, latch req_write, req_addr and req_wdata, then go to SETUP.
  - When req_valid=0, remain in IDLE.
  - req_valid while not ready is ignored; the host must hold the request until accepted.
- SETUP (1 cycle):
  - rw = latched write.
  - in_bus = latched wdata for a write, 0 for a read.
  - sel_x = 0.
- ACCESS (ACCESS_CYC cycles, counted by an internal down-counter):
  - sel_x = 1 << latched addr; rw and in_bus unchanged from SETUP.
  - For a read, rsp_rdata <= out_bus on the edge that leaves ACCESS (the last ACCESS cycle).
- RECOVER (1 cycle):
  - sel_x = 0; rw and in_bus still held.
  - rsp_valid = 1 and rsp_write = latched write.
- Returning to IDLE: rw=0, in_bus=0.
- Latency: with acceptance at edge E0, sel_x is high from after E1 to E(1+ACCESS_CYC), rsp_valid is high in the cycle after E(1+ACCESS_CYC), and req_ready returns after E(2+ACCESS_CYC).
  - ACCESS_CYC=1 gives rsp_valid 3 cycles after acceptance and a throughput of 1 request per 4 cycles.
- Invariants (must hold in every cycle):
  - sel_x is zero or one-hot.
  - rw and in_bus never change in a cycle where sel_x != 0.
  - sel_x is never asserted in the same cycle that rw changes.
- Write completion: rsp_rdata is unchanged.
- There is no response backpressure; rsp_valid is a single-cycle pulse.
- Reset mid-operation: all outputs return to their reset values on the next edge and no rsp_valid is issued. A write interrupted during ACCESS may leave the row partially updated; this is acceptable and documented.
- Address range: every address is valid (ROWS = 2**ADDR_W).

Test Plan:
- Reset then idle: hold rst 2 cycles -> sel_x=0, rw=0, rsp_valid=0, req_ready=0 during rst, req_ready=1 on the first cycle after.
- Write then read: write 8'h55 to addr 2, then read addr 2.
  - Write: sel_x=4'b0100 for exactly 1 cycle, rw=1 from SETUP through RECOVER, rsp_valid pulse with rsp_write=1.
  - Read: rsp_rdata=8'h55, rsp_valid 3 cycles after acceptance.
- Row isolation: write 8'hCC to addr 1 and 8'h33 to addr 3, then read both -> 8'hCC and 8'h33; sel_x is never multi-hot.
- Back-to-back: req_valid held high with 4 writes to addresses 0..3 -> acceptances spaced exactly 4 cycles apart; each write produces one rsp_valid pulse.
- ACCESS_CYC=3: read addr 0 after writing 8'hA5 -> sel_x=4'b0001 for 3 cycles, rsp_rdata=8'hA5, rsp_valid 5 cycles after acceptance.
- Mid-operation reset: assert rst during ACCESS of a read -> next cycle sel_x=0, no rsp_valid, rsp_rdata=0; a following read of a previously written row (8'h0F) returns 8'h0F.
